// File: rtl/sm83_irq_ctl_if.sv
// ----------------------------------------------------------------------------
// sm83_irq_ctl_if
// Bundles the interrupt controller's core-side signals.
//   master : the CPU core / peripheral side (drives requests, decode strobes)
//   slave  : the interrupt controller (drives IF readback, IME and dispatch)
// Signals:
//   mcycle_en                 M-cycle strobe; controller state only moves on it
//   ie_reg[7:0]               IE register (bits 4:0 meaningful)
//   if_set[4:0]               peripheral request pulses
//   if_wr_en, if_wr_data[4:0] CPU write to IF
//   if_rd[7:0]                IF readback, bits 7:5 read as 1
//   instr_boundary            last M-cycle of the current instruction
//   ei, di, reti, halt_req    decode strobes, coincident with instr_boundary
//   ime, halted, busy         controller status
//   irq_take                  abort next fetch and enter dispatch
//   push_hi, push_lo, pc_load dispatch micro-op strobes
//   vector[15:0]              dispatch target
// ----------------------------------------------------------------------------
interface sm83_irq_ctl_if;
    logic        mcycle_en;
    logic [7:0]  ie_reg;
    logic [4:0]  if_set;
    logic        if_wr_en;
    logic [4:0]  if_wr_data;
    logic [7:0]  if_rd;
    logic        instr_boundary;
    logic        ei;
    logic        di;
    logic        reti;
    logic        halt_req;
    logic        ime;
    logic        halted;
    logic        irq_take;
    logic        push_hi;
    logic        push_lo;
    logic        pc_load;
    logic [15:0] vector;
    logic        busy;

    modport master (
        output mcycle_en, ie_reg, if_set, if_wr_en, if_wr_data,
               instr_boundary, ei, di, reti, halt_req,
        input  if_rd, ime, halted, irq_take, push_hi, push_lo, pc_load,
               vector, busy
    );

    modport slave (
        input  mcycle_en, ie_reg, if_set, if_wr_en, if_wr_data,
               instr_boundary, ei, di, reti, halt_req,
        output if_rd, ime, halted, irq_take, push_hi, push_lo, pc_load,
               vector, busy
    );
endinterface

// File: rtl/sm83_irq_ctl.sv
// ----------------------------------------------------------------------------
// sm83_irq_ctl
// SM83-style interrupt controller: IF register, IME with delayed EI, HALT
// handling and the five M-cycle dispatch sequence (two waits, push PCH,
// push PCL, jump to vector).
// Ports:
//   clk    core clock
//   rst_n  asynchronous active-low reset
//   bus    sm83_irq_ctl_if.slave (see interface header for signal list)
// ----------------------------------------------------------------------------
module sm83_irq_ctl (
    input  logic          clk,
    input  logic          rst_n,
    sm83_irq_ctl_if.slave bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WAIT1  = 3'd1;
    localparam logic [2:0] WAIT2  = 3'd2;
    localparam logic [2:0] PUSH_H = 3'd3;
    localparam logic [2:0] PUSH_L = 3'd4;
    localparam logic [2:0] JUMP   = 3'd5;

    // Isolates the lowest set bit (highest priority request).
    function automatic logic [4:0] lowest_onehot(input logic [4:0] v);
        lowest_onehot = v & (~v + 5'd1);
    endfunction

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] lowest_index(input logic [4:0] v);
        logic [2:0] idx;
        casez (v)
            5'b????1: idx = 3'd0;
            5'b???10: idx = 3'd1;
            5'b??100: idx = 3'd2;
            5'b?1000: idx = 3'd3;
            5'b10000: idx = 3'd4;
            default:  idx = 3'd0;
        endcase
        return idx;
    endfunction

    logic [2:0]  state_r;
    logic [2:0]  state_next_s;
    logic [4:0]  if_r;
    logic [4:0]  if_next_s;
    logic        ime_r;
    logic        ime_dec_s;
    logic        ime_next_s;
    logic        ei_pend_r;
    logic        ei_pend_next_s;
    logic        halted_r;
    logic        halted_next_s;
    logic [15:0] vector_r;
    logic [15:0] vector_next_s;

    logic [4:0]  pending_s;
    logic        any_pend_s;
    logic        idle_s;
    logic        bnd_s;
    logic        eff_ime_s;
    logic        take_s;
    logic        resample_s;
    logic [4:0]  clr_mask_s;
    logic        unused_ie_s;

    assign unused_ie_s = ^bus.ie_reg[7:5];

    // Request qualification: pending set, boundary decode and dispatch start.
    always_comb begin
        pending_s  = bus.ie_reg[4:0] & if_r;
        any_pend_s = |pending_s;
        idle_s     = (state_r == IDLE);
        // Decode strobes only count at a boundary of a running (not halted,
        // not dispatching) core.
        bnd_s      = bus.mcycle_en & idle_s & ~halted_r & bus.instr_boundary;
        // RETI enables at its own boundary; DI blocks the check immediately.
        // A pending EI promotion deliberately does not feed this term.
        eff_ime_s  = bus.reti | (ime_r & ~bus.di);
        if (halted_r) begin
            // Wake with IME set dispatches in the wake cycle itself.
            take_s = bus.mcycle_en & idle_s & any_pend_s & ime_r;
        end else begin
            take_s = bnd_s & eff_ime_s & any_pend_s;
        end
        resample_s = bus.mcycle_en & (state_r == PUSH_H);
    end

    // IF next value: write, then dispatch clear, with peripheral set winning.
    always_comb begin
        if (resample_s) begin
            clr_mask_s = lowest_onehot(pending_s);
        end else begin
            clr_mask_s = 5'd0;
        end
        if (bus.if_wr_en) begin
            if_next_s = (bus.if_wr_data & ~clr_mask_s) | bus.if_set;
        end else begin
            if_next_s = (if_r & ~clr_mask_s) | bus.if_set;
        end
    end

    // IME / EI-delay next state; dispatch entry always wins and clears IME.
    always_comb begin
        ime_dec_s      = ime_r;
        ei_pend_next_s = ei_pend_r;
        if (bnd_s) begin
            ei_pend_next_s = bus.ei & ~bus.di;
            if (bus.di) begin
                ime_dec_s = 1'b0;
            end else if (bus.reti | ei_pend_r) begin
                ime_dec_s = 1'b1;
            end else begin
                ime_dec_s = ime_r;
            end
        end else begin
            ei_pend_next_s = ei_pend_r;
        end
        ime_next_s = take_s ? 1'b0 : ime_dec_s;
    end

    // HALT entry/exit; a pending request always wakes, independent of IME.
    always_comb begin
        if (bus.mcycle_en & idle_s & halted_r & any_pend_s) begin
            halted_next_s = 1'b0;
        end else if (bnd_s & bus.halt_req & ~any_pend_s) begin
            halted_next_s = 1'b1;
        end else begin
            halted_next_s = halted_r;
        end
    end

    // Vector latch at the end of PUSH_H; IE may have been cleared by the
    // PCH stack write, in which case dispatch lands on 0x0000.
    always_comb begin
        if (resample_s) begin
            if (any_pend_s) begin
                vector_next_s = 16'h0040 + {10'd0, lowest_index(pending_s), 3'b000};
            end else begin
                vector_next_s = 16'h0000;
            end
        end else begin
            vector_next_s = vector_r;
        end
    end

    // Dispatch sequencer next state.
    always_comb begin
        state_next_s = state_r;
        if (bus.mcycle_en) begin
            case (state_r)
                IDLE:    state_next_s = take_s ? WAIT1 : IDLE;
                WAIT1:   state_next_s = WAIT2;
                WAIT2:   state_next_s = PUSH_H;
                PUSH_H:  state_next_s = PUSH_L;
                PUSH_L:  state_next_s = JUMP;
                JUMP:    state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // State registers; everything advances only on the M-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            if_r      <= 5'd0;
            ime_r     <= 1'b0;
            ei_pend_r <= 1'b0;
            halted_r  <= 1'b0;
            vector_r  <= 16'h0000;
        end else if (bus.mcycle_en) begin
            state_r   <= state_next_s;
            if_r      <= if_next_s;
            ime_r     <= ime_next_s;
            ei_pend_r <= ei_pend_next_s;
            halted_r  <= halted_next_s;
            vector_r  <= vector_next_s;
        end
    end

    assign bus.if_rd    = {3'b111, if_r};
    assign bus.ime      = ime_r;
    assign bus.halted   = halted_r;
    assign bus.busy     = ~idle_s;
    assign bus.irq_take = take_s;
    assign bus.push_hi  = bus.mcycle_en & (state_r == PUSH_H);
    assign bus.push_lo  = bus.mcycle_en & (state_r == PUSH_L);
    assign bus.pc_load  = bus.mcycle_en & (state_r == JUMP);
    assign bus.vector   = vector_r;

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// ----------------------------------------------------------------------------
// tb_sm83_irq_ctl
// Stimulus issues one input vector per clock and a reference model pushes the
// expected status and dispatch strobes into queues; a monitor on the falling
// edge pops and compares. Directed scenarios are followed by random traffic.
// ----------------------------------------------------------------------------
module tb_sm83_irq_ctl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sm83_irq_ctl_if bus ();

    sm83_irq_ctl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0]  if_rd;
        logic        ime;
        logic        halted;
        logic        busy;
        logic [15:0] vector;
        logic [3:0]  strobes;   // {pc_load, push_lo, push_hi, irq_take}
    } status_t;

    typedef struct packed {
        logic [1:0]  kind;      // 0 take, 1 push_hi, 2 push_lo, 3 pc_load
        logic [15:0] vector;
    } event_t;

    status_t st_q[$];
    event_t  ev_q[$];

    // staged stimulus for the next cycle
    logic       s_en;
    logic [7:0] s_ie;
    logic [4:0] s_set;
    logic       s_wr;
    logic [4:0] s_wd;
    logic       s_bnd, s_ei, s_di, s_reti, s_halt;

    // reference model state
    logic [4:0]  m_if;
    logic        m_ime, m_ei_pend, m_halted;
    int          m_phase;   // 0 idle, 1..5 = M-cycles into the dispatch
    logic [15:0] m_vector;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_if = 5'd0; m_ime = 1'b0; m_ei_pend = 1'b0; m_halted = 1'b0;
        m_phase = 0; m_vector = 16'h0000;
    endtask

    task automatic clr_pulses();
        s_set = 5'd0; s_wr = 1'b0; s_wd = 5'd0;
        s_bnd = 1'b0; s_ei = 1'b0; s_di = 1'b0; s_reti = 1'b0; s_halt = 1'b0;
    endtask

    task automatic bus_quiet();
        bus.mcycle_en = 1'b0; bus.ie_reg = 8'h00; bus.if_set = 5'd0;
        bus.if_wr_en = 1'b0; bus.if_wr_data = 5'd0; bus.instr_boundary = 1'b0;
        bus.ei = 1'b0; bus.di = 1'b0; bus.reti = 1'b0; bus.halt_req = 1'b0;
    endtask

    // Expected behaviour for the cycle being driven, then advance to the next.
    task automatic model_eval();
        logic [4:0] pend, clr;
        logic       take, dec;
        status_t    st;
        event_t     ev;
        pend = s_ie[4:0] & m_if;
        clr  = 5'd0;
        take = 1'b0;
        dec  = s_en && (m_phase == 0) && !m_halted && s_bnd;
        if (s_en && m_phase == 0) begin
            if (m_halted) take = (pend != 5'd0) && m_ime;
            else          take = s_bnd && (pend != 5'd0) && (s_reti || (m_ime && !s_di));
        end
        st.if_rd = {3'b111, m_if}; st.ime = m_ime; st.halted = m_halted;
        st.busy = (m_phase != 0); st.vector = m_vector; st.strobes = 4'd0;
        if (take) begin
            st.strobes[0] = 1'b1;
            ev.kind = 2'd0; ev.vector = m_vector; ev_q.push_back(ev);
        end
        if (s_en && m_phase >= 3) begin
            st.strobes[m_phase - 2] = 1'b1;
            ev.kind = 2'(m_phase - 2); ev.vector = m_vector; ev_q.push_back(ev);
        end
        st_q.push_back(st);
        if (s_en) begin
            if (m_phase == 3) begin
                m_vector = 16'h0000;
                for (int n = 4; n >= 0; n--) begin
                    if (pend[n]) begin
                        m_vector = 16'h0040 + 16'(8 * n);
                        clr = 5'(1 << n);
                    end
                end
            end
            m_if = ((s_wr ? s_wd : m_if) & ~clr) | s_set;
            if (dec) begin
                if (s_di) m_ime = 1'b0;
                else if (s_reti || m_ei_pend) m_ime = 1'b1;
                m_ei_pend = s_ei && !s_di;
            end
            if (take) m_ime = 1'b0;
            if (m_phase == 0) begin
                if (m_halted && pend != 5'd0) m_halted = 1'b0;
                else if (dec && s_halt && pend == 5'd0) m_halted = 1'b1;
            end
            if (take) m_phase = 1;
            else if (m_phase == 5) m_phase = 0;
            else if (m_phase > 0) m_phase = m_phase + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        bus.mcycle_en = s_en; bus.ie_reg = s_ie; bus.if_set = s_set;
        bus.if_wr_en = s_wr; bus.if_wr_data = s_wd; bus.instr_boundary = s_bnd;
        bus.ei = s_ei; bus.di = s_di; bus.reti = s_reti; bus.halt_req = s_halt;
        model_eval();
        clr_pulses();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: compares DUT outputs to the queued expectations mid-cycle.
    always @(negedge clk) begin
        status_t    st;
        event_t     ev;
        logic [3:0] got;
        if (rst_n && st_q.size() > 0) begin
            st  = st_q.pop_front();
            got = {bus.pc_load, bus.push_lo, bus.push_hi, bus.irq_take};
            chk("if_rd",   32'(bus.if_rd),  32'(st.if_rd));
            chk("ime",     32'(bus.ime),    32'(st.ime));
            chk("halted",  32'(bus.halted), 32'(st.halted));
            chk("busy",    32'(bus.busy),   32'(st.busy));
            chk("vector",  32'(bus.vector), 32'(st.vector));
            chk("strobes", 32'(got),        32'(st.strobes));
            if (got != 4'd0) begin
                if (ev_q.size() == 0) begin
                    chk("unexpected_strobe", 32'(got), 32'd0);
                end else begin
                    ev = ev_q.pop_front();
                    chk("event_kind", 32'(got), 32'(4'd1 << ev.kind));
                    if (ev.kind == 2'd3) chk("jump_vector", 32'(bus.vector), 32'(ev.vector));
                end
            end
        end
    end

    initial begin
        bus_quiet();
        clr_pulses();
        model_reset();
        s_en = 1'b1; s_ie = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_if_rd",  32'(bus.if_rd),  32'hE0);
        chk("reset_vector", 32'(bus.vector), 32'h0000);
        chk("reset_busy",   32'(bus.busy),   32'd0);
        rst_n = 1'b1;

        // basic dispatch: RETI sets IME, Timer request -> 0x0050
        s_ie = 8'h04; s_bnd = 1'b1; s_reti = 1'b1; tick();
        s_set = 5'h04; tick();
        s_bnd = 1'b1; tick();
        idle(6);
        chk("basic_vector", 32'(bus.vector), 32'h0050);
        chk("basic_if",     32'(bus.if_rd),  32'hE0);
        chk("basic_ime",    32'(bus.ime),    32'd0);

        // priority + EI delay: IF=0x12, dispatch at second boundary after EI
        s_ie = 8'h1F; s_wr = 1'b1; s_wd = 5'h12; tick();
        s_bnd = 1'b1; s_ei = 1'b1; tick();
        s_bnd = 1'b1; tick();
        s_bnd = 1'b1; tick();
        idle(6);
        chk("ei_vector", 32'(bus.vector), 32'h0048);
        chk("ei_if",     32'(bus.if_rd),  32'hF0);

        // IE cleared during PUSH_H -> vector 0x0000, IF untouched
        s_wr = 1'b1; s_wd = 5'h00; tick();
        s_ie = 8'h01; s_set = 5'h01; s_bnd = 1'b1; s_reti = 1'b1; tick();
        s_bnd = 1'b1; tick();
        idle(2);
        s_ie = 8'h00; tick();
        idle(4);
        chk("cancel_vector", 32'(bus.vector), 32'h0000);
        chk("cancel_if",     32'(bus.if_rd),  32'hE1);

        // HALT wake with IME=0: no dispatch
        s_wr = 1'b1; s_wd = 5'h00; s_ie = 8'h10; tick();
        s_bnd = 1'b1; s_halt = 1'b1; tick();
        idle(1);
        chk("halt_enter", 32'(bus.halted), 32'd1);
        s_set = 5'h10; tick();
        tick();
        idle(1);
        chk("halt_wake",      32'(bus.halted), 32'd0);
        chk("halt_wake_busy", 32'(bus.busy),   32'd0);
        // HALT wake with IME=1: dispatch to Joypad vector
        s_wr = 1'b1; s_wd = 5'h00; tick();
        s_bnd = 1'b1; s_reti = 1'b1; tick();
        s_bnd = 1'b1; s_halt = 1'b1; tick();
        idle(1);
        chk("halt2_enter", 32'(bus.halted), 32'd1);
        s_set = 5'h10; tick();
        tick();
        idle(6);
        chk("halt2_vector", 32'(bus.vector), 32'h0060);
        chk("halt2_halted", 32'(bus.halted), 32'd0);

        // collisions: if_set beats CPU write and dispatch clear
        s_ie = 8'h01; s_wr = 1'b1; s_wd = 5'h00; s_set = 5'h01; tick();
        idle(1);
        chk("wr_vs_set", 32'(bus.if_rd), 32'hE1);
        s_bnd = 1'b1; s_reti = 1'b1; tick();
        idle(2);
        s_set = 5'h01; tick();
        idle(4);
        chk("clr_vs_set_if",     32'(bus.if_rd),  32'hE1);
        chk("clr_vs_set_vector", 32'(bus.vector), 32'h0040);

        // reset asserted while in PUSH_L
        s_wr = 1'b1; s_wd = 5'h09; tick();
        s_bnd = 1'b1; s_reti = 1'b1; tick();
        idle(4);
        @(negedge clk); #2;
        rst_n = 1'b0;
        bus_quiet();
        #1;
        chk("rst_busy",    32'(bus.busy),    32'd0);
        chk("rst_push_lo", 32'(bus.push_lo), 32'd0);
        chk("rst_pc_load", 32'(bus.pc_load), 32'd0);
        chk("rst_if_rd",   32'(bus.if_rd),   32'hE0);
        chk("rst_ime",     32'(bus.ime),     32'd0);
        chk("rst_vector",  32'(bus.vector),  32'h0000);
        st_q.delete();
        ev_q.delete();
        model_reset();
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle(2);

        // random traffic
        s_ie = 8'h00;
        for (int c = 0; c < 4000; c++) begin
            s_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) s_ie = 8'($urandom);
            for (int b = 0; b < 5; b++) s_set[b] = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 19) == 0) begin
                s_wr = 1'b1;
                s_wd = 5'($urandom);
            end
            if (m_phase != 0 || (!m_halted && $urandom_range(0, 2) == 0)) begin
                s_bnd = (m_phase != 0) ? 1'($urandom) : 1'b1;
                case ($urandom_range(0, 7))
                    0:       s_ei = 1'b1;
                    1:       s_di = 1'b1;
                    2:       s_reti = 1'b1;
                    3:       s_halt = 1'b1;
                    default: s_ei = 1'b0;
                endcase
            end
            tick();
        end
        s_en = 1'b1;
        idle(8);
        @(negedge clk); #1;
        chk("events_drained", 32'(ev_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sm83_irq_ctl.md
SM83_IRQ_CTL -- requirements
Module: sm83_irq_ctl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  core clock; rst_n  in  1  async active-low reset.
REQ-002 SHALL have the following ports:
- mcycle_en  in  1  M-cycle strobe; all state advances only when high.
- ie_reg  in  8  IE register value; bits 4:0 used.
- if_set  in  5  peripheral request pulses (0 VBlank, 1 STAT, 2 Timer, 3 Serial, 4 Joypad).
- if_wr_en  in  1  CPU write strobe to IF.
- if_wr_data  in  5  IF write data.
- if_rd  out  8  IF readback; bits 7:5 read as 1.
- instr_boundary  in  1  last M-cycle of the current instruction.
- ei / di / reti  in  1 each  decode strobes, coincident with instr_boundary.
- halt_req  in  1  HALT executing, coincident with instr_boundary.
- ime  out  1  interrupt master enable.
- halted  out  1  core held in HALT.
- irq_take  out  1  abort next fetch and enter dispatch.
- push_hi / push_lo  out  1 each  core writes PCH / PCL to the stack (SP pre-decremented).
- pc_load  out  1  core loads PC from vector.
- vector  out  16  dispatch target.
- busy  out  1  dispatch FSM not idle.

Function
REQ-003 SHALL hold IF[4:0]; per cycle next = (if_wr_en ? if_wr_data : IF) & ~clr_mask | if_set; if_set wins over write and over dispatch clear.
REQ-004 SHALL compute pending = ie_reg[4:0] & IF[4:0]; the lowest set bit has highest priority.
REQ-005 SHALL implement EI delay: ei at a boundary sets ei_pend; the next boundary with ei_pend set sets ime=1 and clears ei_pend; the interrupt check at that boundary uses the old ime.
REQ-006 SHALL implement di as an immediate clear of ime and ei_pend; di takes precedence over a concurrent ei_pend promotion.
REQ-007 SHALL implement reti as setting ime=1 at its boundary; the interrupt check at that same boundary uses ime=1.
REQ-008 SHALL use FSM states IDLE, WAIT1, WAIT2, PUSH_H, PUSH_L, JUMP; each transition requires mcycle_en.
REQ-009 SHALL transition IDLE->WAIT1 when instr_boundary & effective ime & |pending; in that cycle irq_take=1 (one clk) and ime is cleared.
REQ-010 SHALL sequence WAIT1->WAIT2->PUSH_H->PUSH_L->JUMP->IDLE, with push_hi high in PUSH_H, push_lo high in PUSH_L and pc_load high in JUMP; each strobe is qualified by mcycle_en.
REQ-011 SHALL resample pending at the end of PUSH_H, with the following results:
- Bit n pending: latch vector = 16'h0040 + 8*n and set clr_mask bit n for one cycle.
- None pending (IE cleared by the stack write): latch vector = 16'h0000 and clear no bit.
REQ-012 SHALL hold vector stable from the PUSH_H exit until the next dispatch.
REQ-013 SHALL set halted=1 at the halt_req boundary when pending==0, regardless of ime.
REQ-014 SHALL clear halted at the next mcycle_en with |pending, regardless of ime; if ime=1, dispatch starts from the same cycle as the wake.
REQ-015 SHALL treat halt_req with |pending and ime=0 as a NOP; the HALT bug is not modelled.
REQ-016 SHALL ignore ei/di/reti/instr_boundary while busy; busy=1 in every non-IDLE state.

Reset
REQ-017 SHALL force the following on rst_n low, asynchronously and mid-dispatch included:
- State IDLE, IF=0 (if_rd=8'hE0), ime=0, ei_pend=0, halted=0.
- irq_take, push_hi, push_lo and pc_load low; vector=16'h0000.
REQ-018 SHALL begin operation on the first clk edge after rst_n deasserts; no pending strobe is retained.

Verification
REQ-019 Basic dispatch: ime=1, IE=0x04, pulse if_set[2], then boundary -> irq_take; after 5 M-cycles push_hi, push_lo, pc_load; vector=0x0050; IF[2]=0; ime=0.
REQ-020 Priority and EI delay: IE=0x1F, IF=0x12, ime=0; EI then one instruction -> dispatch only at the second boundary, vector=0x0048, IF=0x10.
REQ-021 IE cancellation: IE cleared during PUSH_H -> vector=0x0000; IF unchanged.
REQ-022 HALT wake: ime=0, halt_req with pending=0 -> halted=1; if_set[4] with IE[4]=1 -> halted=0, no irq_take. Repeat with ime=1 -> dispatch to 0x0060.
REQ-023 Collision: if_wr_en clearing IF[0] in the same cycle as if_set[0] -> IF[0]=1. Dispatch clear of bit 0 concurrent with if_set[0] -> IF[0]=1.
REQ-024 Reset mid-dispatch: rst_n low in PUSH_L -> busy=0, strobes low, if_rd=0xE0, ime=0 immediately, without waiting for a clock edge.
